// File: rtl/rgb565_pkg.sv
// rtl/rgb565_pkg.sv - shared types, field widths and colour-bar constants for the RGB565 packer
//
// Purpose: FSM state encoding, RGB565 field widths, counter width, the eight
//          colour-bar values and the two pixel helpers used by rgb565_packer
//          and rgb565_pack_pair.
// Ports:   none (package).

package rgb565_pkg;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_ARMED  = 2'd1,
        S_ACTIVE = 2'd2,
        S_DROP   = 2'd3
    } state_e;

    localparam int R_W    = 5;
    localparam int G_W    = 6;
    localparam int B_W    = 5;
    localparam int PIX_W  = R_W + G_W + B_W;
    localparam int WORD_W = 2 * PIX_W;
    localparam int CNT_W  = 12;
    localparam int N_BARS = 8;

    localparam logic [PIX_W-1:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [PIX_W-1:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [PIX_W-1:0] BAR_CYAN    = 16'h07FF;
    localparam logic [PIX_W-1:0] BAR_GREEN   = 16'h07E0;
    localparam logic [PIX_W-1:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [PIX_W-1:0] BAR_RED     = 16'hF800;
    localparam logic [PIX_W-1:0] BAR_BLUE    = 16'h001F;
    localparam logic [PIX_W-1:0] BAR_BLACK   = 16'h0000;

    // Keep the top bits of each 8-bit channel.
    function automatic logic [PIX_W-1:0] to_rgb565(input logic [23:0] c);
        return {c[23 -: R_W], c[15 -: G_W], c[7 -: B_W]};
    endfunction

    function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] idx);
        logic [PIX_W-1:0] col;
        case (idx)
            3'd0:    col = BAR_WHITE;
            3'd1:    col = BAR_YELLOW;
            3'd2:    col = BAR_CYAN;
            3'd3:    col = BAR_GREEN;
            3'd4:    col = BAR_MAGENTA;
            3'd5:    col = BAR_RED;
            3'd6:    col = BAR_BLUE;
            default: col = BAR_BLACK;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/rgb565_pack_pair.sv
// rtl/rgb565_pack_pair.sv - pairs RGB565 pixels into 32-bit words and issues the write strobe
//
// Purpose: holds the first pixel of a pair, builds {second, first} on the
//          second pixel, or {16'h0, first} on a line-end flush, and registers
//          the write one cycle later. A blocked write is dropped here; the
//          caller reacts to write_due_o & block_i.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   clear_i           discard any held half-pair
//   pix_valid_i       sample pix_i this cycle
//   pix_i[15:0]       RGB565 pixel
//   flush_i           line end: write a held half-pair on its own
//   block_i           downstream full; suppress a due write
//   write_due_o       a word is due this cycle (before blocking)
//   wr_en_o           one-cycle write strobe
//   wr_data_o[31:0]   packed word, stable while wr_en_o is high

module rgb565_pack_pair
    import rgb565_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              pix_valid_i,
    input  logic [PIX_W-1:0]  pix_i,
    input  logic              flush_i,
    input  logic              block_i,
    output logic              write_due_o,
    output logic              wr_en_o,
    output logic [WORD_W-1:0] wr_data_o
);

    logic              half_q, half_d;
    logic [PIX_W-1:0]  low_q, low_d;
    logic              wr_en_q, wr_en_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic [WORD_W-1:0] word_c;
    logic              do_write;

    // pix_valid_i and flush_i are mutually exclusive (href high vs. href falling).
    assign write_due_o = half_q & ~clear_i & (pix_valid_i | flush_i);
    assign do_write    = write_due_o & ~block_i;
    assign word_c      = pix_valid_i ? {pix_i, low_q} : {{PIX_W{1'b0}}, low_q};

    always_comb begin
        half_d    = half_q;
        low_d     = low_q;
        wr_en_d   = do_write;
        wr_data_d = do_write ? word_c : wr_data_q;
        if (clear_i) begin
            half_d = 1'b0;
        end else if (pix_valid_i) begin
            if (half_q) begin
                half_d = 1'b0;
            end else begin
                half_d = 1'b1;
                low_d  = pix_i;
            end
        end else if (flush_i) begin
            half_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            half_q    <= 1'b0;
            low_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            half_q    <= half_d;
            low_q     <= low_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_data_o = wr_data_q;

endmodule

// File: rtl/rgb565_packer.sv
// rtl/rgb565_packer.sv - frames demosaic RGB888 output into packed RGB565 SDRAM FIFO writes
//
// Purpose: aligns href/vsync with the registered pixel bus, tracks frames
//          with a four-state FSM and pixel/line counters, and hands pixels
//          to rgb565_pack_pair. Optional colour-bar test pattern under
//          macro RGB565_PACKER_TESTPAT_EN (adds input test_en).
// Ports:
//   pclk            pixel clock
//   rst_n           asynchronous active-low reset
//   in_href         line valid (same as the demosaic input)
//   in_vsync        frame sync, active high
//   rgb888[23:0]    demosaic output, one cycle behind in_href
//   fifo_full       SDRAM write FIFO full
//   test_en         (RGB565_PACKER_TESTPAT_EN only) replace pixels by colour bars
//   wr_en           one-cycle write strobe
//   wr_data[31:0]   two packed RGB565 pixels, first in [15:0]
//   frame_start     one-cycle pulse at frame start
//   frame_done      one-cycle pulse after the last word of a complete frame
//   overflow        sticky FIFO overflow flag for the current frame

module rgb565_packer
    import rgb565_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        in_href,
    input  logic        in_vsync,
    input  logic [23:0] rgb888,
    input  logic        fifo_full,
`ifdef RGB565_PACKER_TESTPAT_EN
    input  logic        test_en,
`endif
    output logic        wr_en,
    output logic [31:0] wr_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        overflow
);

    state_e           state_q, state_d;
    logic             href_d, vs_d;
    logic             href_prev_q, vs_prev_q;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic             frame_start_q, frame_start_d;
    logic             overflow_q, overflow_d;

    logic             vs_rise, vs_fall, href_fall;
    logic             line_open, act;
    logic             pix_valid, line_end, overflow_hit, frame_done_c;
    logic             write_due;
    logic [PIX_W-1:0] pix565;
    logic             unused_bits;

    assign vs_rise   = vs_d & ~vs_prev_q;
    assign vs_fall   = ~vs_d & vs_prev_q;
    assign href_fall = ~href_d & href_prev_q;
    assign line_open = line_cnt_q < CNT_W'(V_ACTIVE);

    // A vsync rise mid-frame kills this cycle's sample/flush so a pending
    // half-pair is discarded rather than written.
    assign act          = (state_q == S_ACTIVE) & ~vs_rise;
    assign pix_valid    = act & href_d & line_open & (pix_cnt_q < CNT_W'(H_ACTIVE));
    assign line_end     = act & href_fall & line_open;
    assign overflow_hit = write_due & fifo_full;

    // All lines taken; wait out a final flush write still on the strobe.
    assign frame_done_c = (state_q == S_ACTIVE) & ~line_open & ~wr_en;

`ifdef RGB565_PACKER_TESTPAT_EN
    localparam int BAR_W = (H_ACTIVE / N_BARS > 0) ? H_ACTIVE / N_BARS : 1;
    logic [CNT_W-1:0] bar_full;
    logic [2:0]       bar_idx;

    assign bar_full = pix_cnt_q / CNT_W'(BAR_W);
    assign bar_idx  = (bar_full > CNT_W'(N_BARS - 1)) ? 3'(N_BARS - 1) : bar_full[2:0];
    assign pix565   = test_en ? bar_color(bar_idx) : to_rgb565(rgb888);
`else
    assign pix565   = to_rgb565(rgb888);
`endif

    // Low-order channel bits are truncated away by the RGB565 conversion.
    assign unused_bits = ^{rgb888[18:16], rgb888[9:8], rgb888[2:0]};

    rgb565_pack_pair u_pair (
        .clk_i       (pclk),
        .rst_ni      (rst_n),
        .clear_i     (~act),
        .pix_valid_i (pix_valid),
        .pix_i       (pix565),
        .flush_i     (line_end),
        .block_i     (fifo_full),
        .write_due_o (write_due),
        .wr_en_o     (wr_en),
        .wr_data_o   (wr_data)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_WAIT;
            href_d        <= 1'b0;
            vs_d          <= 1'b0;
            href_prev_q   <= 1'b0;
            vs_prev_q     <= 1'b0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            frame_start_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            href_d        <= in_href;
            vs_d          <= in_vsync;
            href_prev_q   <= href_d;
            vs_prev_q     <= vs_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            frame_start_q <= frame_start_d;
            overflow_q    <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (vs_d) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (vs_fall) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (overflow_hit) begin
                    state_d = S_DROP;
                end else if (!line_open) begin
                    // Complete frame: frame_done wins over a coincident vsync rise.
                    if (frame_done_c) state_d = S_ARMED;
                end else if (vs_rise) begin
                    state_d = S_ARMED;
                end
            end
            S_DROP: begin
                if (vs_d) state_d = S_ARMED;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_comb begin
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        frame_start_d = 1'b0;
        overflow_d    = overflow_q;
        if (state_q == S_ARMED && vs_fall) begin
            pix_cnt_d     = '0;
            line_cnt_d    = '0;
            frame_start_d = 1'b1;
            overflow_d    = 1'b0;
        end
        if (pix_valid) begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
        end
        if (line_end) begin
            pix_cnt_d  = '0;
            line_cnt_d = line_cnt_q + CNT_W'(1);
        end
        if (overflow_hit) begin
            overflow_d = 1'b1;
        end
    end

    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_c;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_rgb565_packer.sv
// tb/tb_rgb565_packer.sv - scoreboard bench for rgb565_packer (RGB565_PACKER_TESTPAT_EN adds the bar test)

module tb_rgb565_packer;

    logic        pclk;
    logic        rst_n;
    logic        in_href;
    logic        in_vsync;
    logic [23:0] rgb888;
    logic        fifo_full;
    logic        tp_on;
    logic        tp_off;

    logic        wr_en_a, frame_start_a, frame_done_a, overflow_a;
    logic [31:0] wr_data_a;
    logic        wr_en_b, frame_start_b, frame_done_b, overflow_b;
    logic [31:0] wr_data_b;
    logic        wr_en_c, frame_start_c, frame_done_c, overflow_c;
    logic [31:0] wr_data_c;

    rgb565_packer #(.H_ACTIVE(4), .V_ACTIVE(2)) u_dut_a (
        .pclk(pclk), .rst_n(rst_n), .in_href(in_href), .in_vsync(in_vsync),
        .rgb888(rgb888), .fifo_full(fifo_full),
`ifdef RGB565_PACKER_TESTPAT_EN
        .test_en(tp_off),
`endif
        .wr_en(wr_en_a), .wr_data(wr_data_a), .frame_start(frame_start_a),
        .frame_done(frame_done_a), .overflow(overflow_a)
    );

    rgb565_packer #(.H_ACTIVE(3), .V_ACTIVE(1)) u_dut_b (
        .pclk(pclk), .rst_n(rst_n), .in_href(in_href), .in_vsync(in_vsync),
        .rgb888(rgb888), .fifo_full(fifo_full),
`ifdef RGB565_PACKER_TESTPAT_EN
        .test_en(tp_off),
`endif
        .wr_en(wr_en_b), .wr_data(wr_data_b), .frame_start(frame_start_b),
        .frame_done(frame_done_b), .overflow(overflow_b)
    );

`ifdef RGB565_PACKER_TESTPAT_EN
    rgb565_packer #(.H_ACTIVE(16), .V_ACTIVE(1)) u_dut_c (
        .pclk(pclk), .rst_n(rst_n), .in_href(in_href), .in_vsync(in_vsync),
        .rgb888(rgb888), .fifo_full(fifo_full), .test_en(tp_on),
        .wr_en(wr_en_c), .wr_data(wr_data_c), .frame_start(frame_start_c),
        .frame_done(frame_done_c), .overflow(overflow_c)
    );
`else
    assign {wr_en_c, frame_start_c, frame_done_c, overflow_c} = 4'b0;
    assign wr_data_c = 32'h0;
`endif

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int          vectors = 0;
    int          miscompares = 0;
    int          sel = 0;
    bit          mon_en = 0;
    int          n_wr = 0, n_done = 0, n_start = 0, since_wr = 1000;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    logic [23:0] pix_buf [0:15];

    logic        m_wr_en, m_frame_start, m_frame_done;
    logic [31:0] m_wr_data;

    always_comb begin
        m_wr_en = wr_en_a; m_wr_data = wr_data_a;
        m_frame_start = frame_start_a; m_frame_done = frame_done_a;
        if (sel == 1) begin
            m_wr_en = wr_en_b; m_wr_data = wr_data_b;
            m_frame_start = frame_start_b; m_frame_done = frame_done_b;
        end else if (sel == 2) begin
            m_wr_en = wr_en_c; m_wr_data = wr_data_c;
            m_frame_start = frame_start_c; m_frame_done = frame_done_c;
        end
    end

    // Scoreboard: every write pops the next expected word; frame_done must
    // follow the last write by exactly one cycle.
    always @(negedge pclk) begin
        if (mon_en) begin
            if (m_wr_en) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
                vectors++;
                assert (m_wr_data === exp_w) else begin
                    miscompares++;
                    $error("FAIL wr_data observed=%h expected=%h", m_wr_data, exp_w);
                end
                n_wr++;
                since_wr = 0;
            end else if (since_wr < 1000) begin
                since_wr++;
            end
            if (m_frame_done) begin
                n_done++;
                vectors++;
                assert (since_wr === 1) else begin
                    miscompares++;
                    $error("FAIL frame_done_gap observed=%0d expected=1", since_wr);
                end
            end
            if (m_frame_start) n_start++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_std(input int n);
        for (int i = 0; i < n; i++) begin
            case (i % 4)
                0: pix_buf[i] = 24'hFF0000;
                1: pix_buf[i] = 24'h00FF00;
                2: pix_buf[i] = 24'h0000FF;
                default: pix_buf[i] = 24'hFFFFFF;
            endcase
        end
    endtask

    // rgb888 trails in_href by one cycle; fifo_full is aligned with rgb888.
    task automatic drive_line(input int n, input int full_from, input bit vs_end);
        for (int i = 0; i <= n; i++) begin
            @(negedge pclk);
            in_href   = (i < n);
            rgb888    = (i > 0) ? pix_buf[i-1] : 24'h0;
            fifo_full = (i > 0) && (i - 1 >= full_from);
            if (i == n && vs_end) in_vsync = 1'b1;
        end
        @(negedge pclk);
        rgb888    = 24'h0;
        fifo_full = 1'b0;
        repeat (3) @(negedge pclk);
    endtask

    task automatic vsync_pulse();
        @(negedge pclk);
        in_vsync = 1'b1;
        repeat (3) @(negedge pclk);
        in_vsync = 1'b0;
        repeat (4) @(negedge pclk);
    endtask

    task automatic push4();
        exp_q.push_back(32'h07E0F800); exp_q.push_back(32'hFFFF001F);
        exp_q.push_back(32'h07E0F800); exp_q.push_back(32'hFFFF001F);
    endtask

    task automatic restart_dut(input int which);
        mon_en = 0;
        @(negedge pclk);
        rst_n = 1'b0;
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;
        sel = which;
        n_wr = 0; n_done = 0; n_start = 0; since_wr = 1000;
        exp_q.delete();
        mon_en = 1;
    endtask

    initial begin
        rst_n = 1'b0; in_href = 1'b0; in_vsync = 1'b0; rgb888 = 24'h0;
        fifo_full = 1'b0; tp_on = 1'b1; tp_off = 1'b0;
        repeat (3) @(negedge pclk);
        #2;
        check("rst_wr_en", 32'(wr_en_a), 32'h0);
        check("rst_wr_data", wr_data_a, 32'h0);
        check("rst_frame_start", 32'(frame_start_a), 32'h0);
        check("rst_frame_done", 32'(frame_done_a), 32'h0);
        check("rst_overflow", 32'(overflow_a), 32'h0);
        @(negedge pclk);
        rst_n = 1'b1;
        mon_en = 1;

        // href activity before any vsync must be ignored
        set_std(4);
        drive_line(4, 99, 0);
        drive_line(4, 99, 0);
        check("no_wr_before_vsync", 32'(n_wr), 32'd0);
        @(negedge pclk);
        in_vsync = 1'b1;
        repeat (4) @(negedge pclk);
        check("no_start_while_vs_high", 32'(n_start), 32'd0);
        in_vsync = 1'b0;
        repeat (4) @(negedge pclk);
        check("start_after_vs_fall", 32'(n_start), 32'd1);

        // Frame A: two full lines
        push4();
        drive_line(4, 99, 0);
        drive_line(4, 99, 0);
        repeat (3) @(negedge pclk);
        check("A_wr_count", 32'(n_wr), 32'd4);
        check("A_done_count", 32'(n_done), 32'd1);
        check("A_queue_empty", 32'(exp_q.size()), 32'd0);
        check("A_overflow", 32'(overflow_a), 32'h0);

        // Frame B: over-long line then an odd line flushed on href fall
        vsync_pulse();
        set_std(4);
        pix_buf[4] = 24'h123456; pix_buf[5] = 24'hABCDEF;
        exp_q.push_back(32'h07E0F800); exp_q.push_back(32'hFFFF001F);
        drive_line(6, 99, 0);
        exp_q.push_back(32'h07E0F800); exp_q.push_back(32'h0000001F);
        drive_line(3, 99, 0);
        repeat (3) @(negedge pclk);
        check("B_wr_count", 32'(n_wr), 32'd8);
        check("B_done_count", 32'(n_done), 32'd2);
        check("B_queue_empty", 32'(exp_q.size()), 32'd0);

        // Frame C: FIFO full on the second write slot
        vsync_pulse();
        set_std(4);
        exp_q.push_back(32'h07E0F800);
        drive_line(4, 3, 0);
        check("C_overflow_set", 32'(overflow_a), 32'h1);
        drive_line(4, 99, 0);
        check("C_wr_count", 32'(n_wr), 32'd9);
        check("C_no_done", 32'(n_done), 32'd2);
        check("C_overflow_sticky", 32'(overflow_a), 32'h1);

        // Frame D: overflow held until frame_start, then normal packing
        @(negedge pclk);
        in_vsync = 1'b1;
        repeat (3) @(negedge pclk);
        check("D_overflow_before_start", 32'(overflow_a), 32'h1);
        in_vsync = 1'b0;
        repeat (4) @(negedge pclk);
        check("D_overflow_cleared", 32'(overflow_a), 32'h0);
        check("D_start_count", 32'(n_start), 32'd4);
        push4();
        drive_line(4, 99, 0);
        drive_line(4, 99, 0);
        repeat (3) @(negedge pclk);
        check("D_wr_count", 32'(n_wr), 32'd13);
        check("D_done_count", 32'(n_done), 32'd3);

        // Frame E: vsync rises at line 1 with a half-pair pending
        vsync_pulse();
        exp_q.push_back(32'h07E0F800); exp_q.push_back(32'hFFFF001F);
        exp_q.push_back(32'h07E0F800);
        drive_line(4, 99, 0);
        drive_line(3, 99, 1);
        in_vsync = 1'b0;
        repeat (4) @(negedge pclk);
        check("E_wr_count", 32'(n_wr), 32'd16);
        check("E_no_done", 32'(n_done), 32'd3);
        check("E_start_count", 32'(n_start), 32'd6);

        // Frame F: packs normally after the truncated frame
        push4();
        drive_line(4, 99, 0);
        drive_line(4, 99, 0);
        repeat (3) @(negedge pclk);
        check("F_wr_count", 32'(n_wr), 32'd20);
        check("F_done_count", 32'(n_done), 32'd4);
        check("F_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame: asynchronous clear, then nothing until a new vsync
        vsync_pulse();
        exp_q.push_back(32'h07E0F800); exp_q.push_back(32'hFFFF001F);
        drive_line(4, 99, 0);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_wr_data", wr_data_a, 32'h0);
        check("async_rst_overflow", 32'(overflow_a), 32'h0);
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;
        drive_line(4, 99, 0);
        drive_line(4, 99, 0);
        check("rst_mid_wr_count", 32'(n_wr), 32'd22);
        check("rst_mid_done_count", 32'(n_done), 32'd4);
        check("rst_mid_start_count", 32'(n_start), 32'd7);

        // H_ACTIVE=3 instance: odd line flush
        restart_dut(1);
        vsync_pulse();
        for (int i = 0; i < 3; i++) pix_buf[i] = 24'hFFFFFF;
        exp_q.push_back(32'hFFFFFFFF); exp_q.push_back(32'h0000FFFF);
        drive_line(3, 99, 0);
        repeat (3) @(negedge pclk);
        check("H3_wr_count", 32'(n_wr), 32'd2);
        check("H3_done_count", 32'(n_done), 32'd1);
        check("H3_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef RGB565_PACKER_TESTPAT_EN
        // H_ACTIVE=16 instance with colour bars
        restart_dut(2);
        vsync_pulse();
        for (int i = 0; i < 16; i++) pix_buf[i] = 24'h5A5A5A;
        exp_q.push_back(32'hFFFFFFFF); exp_q.push_back(32'hFFE0FFE0);
        exp_q.push_back(32'h07FF07FF); exp_q.push_back(32'h07E007E0);
        exp_q.push_back(32'hF81FF81F); exp_q.push_back(32'hF800F800);
        exp_q.push_back(32'h001F001F); exp_q.push_back(32'h00000000);
        drive_line(16, 99, 0);
        repeat (3) @(negedge pclk);
        check("TP_wr_count", 32'(n_wr), 32'd8);
        check("TP_done_count", 32'(n_done), 32'd1);
        check("TP_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

        mon_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
